// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM initiator controller and the SRAM block:
// FSM state encoding and write-enable polarity.
package sram_ctrl_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned WAIT_CNT_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_INIT = 3'd0;
    localparam state_t S_IDLE = 3'd1;
    localparam state_t S_WR   = 3'd2;
    localparam state_t S_RD   = 3'd3;
    localparam state_t S_WAIT = 3'd4;
    localparam state_t S_RSP  = 3'd5;

    localparam logic MEM_WE_WRITE = 1'b1;
    localparam logic MEM_WE_READ  = 1'b0;

endpackage

// File: rtl/sram_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM: clears the
// array after reset, then serves word reads/writes over valid/ready channels.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned      ADDR     = 4,
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      LENGTH   = 16,
    parameter int unsigned      RD_LAT   = 1,
    parameter bit               INIT_EN  = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             init_done,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = ADDR + 1;
    localparam logic [CNT_W-1:0]      LEN_C = CNT_W'(LENGTH);
    localparam logic [WAIT_CNT_W-1:0] LAT_C = WAIT_CNT_W'(RD_LAT);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_init_cnt;
    logic [CNT_W-1:0]      w_init_cnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt;

    logic             r_req_ready, w_req_ready;
    logic             r_rsp_valid, w_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
    logic             r_rsp_err,   w_rsp_err;
    logic             r_init_done, w_init_done;
    logic             r_mem_cs,    w_mem_cs;
    logic             r_mem_we,    w_mem_we;
    logic [ADDR-1:0]  r_mem_addr,  w_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata, w_mem_wdata;

    logic w_accept;
    logic w_in_range;

    assign w_accept   = req_valid && r_req_ready;
    assign w_in_range = ({1'b0, req_addr} < LEN_C);

    // State, counters and every output are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT_EN ? S_INIT : S_IDLE;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_init_done <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= MEM_WE_READ;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_next;
            r_init_cnt  <= w_init_cnt;
            r_wait_cnt  <= w_wait_cnt;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_init_done <= w_init_done;
            r_mem_cs    <= w_mem_cs;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    // Out-of-range writes still pass through WR so req_ready drops for a cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: if (r_init_cnt == LEN_C) w_next = S_IDLE;
            S_IDLE: begin
                if (w_accept) begin
                    if (req_we)          w_next = S_WR;
                    else if (w_in_range) w_next = S_RD;
                    else                 w_next = S_RSP;
                end
            end
            S_WR:   w_next = S_IDLE;
            S_RD:   w_next = S_WAIT;
            S_WAIT: if (r_wait_cnt == LAT_C) w_next = S_RSP;
            S_RSP:  if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the wait count starts at 1 on the RD edge
    always_comb begin
        w_init_cnt  = r_init_cnt;
        w_wait_cnt  = r_wait_cnt;
        w_mem_cs    = 1'b0;
        w_mem_we    = MEM_WE_READ;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_init_done = r_init_done || (w_next != S_INIT);
        w_req_ready = (w_next == S_IDLE);
        case (r_state)
            S_INIT: begin
                if (r_init_cnt != LEN_C) begin
                    w_mem_cs    = 1'b1;
                    w_mem_we    = MEM_WE_WRITE;
                    w_mem_addr  = r_init_cnt[ADDR-1:0];
                    w_mem_wdata = INIT_VAL;
                    w_init_cnt  = r_init_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_accept && w_in_range) begin
                    w_mem_cs   = 1'b1;
                    w_mem_we   = req_we ? MEM_WE_WRITE : MEM_WE_READ;
                    w_mem_addr = req_addr;
                    if (req_we) w_mem_wdata = req_wdata;
                end else if (w_accept && !req_we) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = '0;
                    w_rsp_err   = 1'b1;
                end
            end
            S_RD: w_wait_cnt = WAIT_CNT_W'(1);
            S_WAIT: begin
                if (r_wait_cnt == LAT_C) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = mem_rdata;
                    w_rsp_err   = 1'b0;
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            S_RSP: if (r_rsp_valid && rsp_ready) w_rsp_valid = 1'b0;
            default: ;
        endcase
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign init_done = r_init_done;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two controllers (LENGTH 16 / RD_LAT 1 and LENGTH 12 /
// RD_LAT 3) each with a behavioural SRAM, checked against an array model.
module tb_sram_ctrl;

    localparam int NDUT = 2;

    function automatic int unsigned len_of(input int d);
        return (d == 0) ? 16 : 12;
    endfunction
    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic logic [7:0] ival_of(input int d);
        return (d == 0) ? 8'h00 : 8'h5A;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [NDUT];
    logic       req_valid [NDUT];
    logic       req_ready [NDUT];
    logic       req_we    [NDUT];
    logic [3:0] req_addr  [NDUT];
    logic [7:0] req_wdata [NDUT];
    logic       rsp_valid [NDUT];
    logic       rsp_ready [NDUT];
    logic [7:0] rsp_rdata [NDUT];
    logic       rsp_err   [NDUT];
    logic       init_done [NDUT];
    logic       mem_cs    [NDUT];
    logic       mem_we    [NDUT];
    logic [3:0] mem_addr  [NDUT];
    logic [7:0] mem_wdata [NDUT];
    logic [7:0] mem_rdata [NDUT];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [NDUT][16];
    int         cs_cnt [NDUT] = '{0, 0};
    int         viol   [NDUT] = '{0, 0};

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LEN  = len_of(g);
        localparam int unsigned LAT  = lat_of(g);
        localparam logic [7:0]  IVAL = ival_of(g);

        logic [7:0] sram [16];
        logic [7:0] pipe [4];

        sram_ctrl #(
            .ADDR(4), .WIDTH(8), .LENGTH(LEN), .RD_LAT(LAT),
            .INIT_EN(1'b1), .INIT_VAL(IVAL)
        ) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .init_done(init_done[g]),
            .mem_cs(mem_cs[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // SRAM: data read at the RD edge appears LAT edges later
        always @(posedge clk) begin
            if (mem_cs[g] && mem_we[g]) sram[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= (mem_cs[g] && !mem_we[g]) ? sram[mem_addr[g]] : 8'hEE;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    // Bus monitor: chip-select pulses and protocol violations per controller
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (mem_cs[k]) cs_cnt[k] <= cs_cnt[k] + 1;
            if ((!mem_cs[k] && mem_we[k]) || (mem_cs[k] && 32'(mem_addr[k]) >= len_of(k)))
                viol[k] <= viol[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        chk($sformatf("d%0d_%s_zero", d, tag),
            32'({req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d], init_done[d],
                 mem_cs[d], mem_we[d], mem_addr[d], mem_wdata[d]}), 32'd0);
    endtask

    task automatic reset_pulse(input int d);
        rst_n[d] = 1'b0;
        #1;
        check_zero(d, "rst_async");
        @(negedge clk);
        check_zero(d, "rst_held");
    endtask

    // Releases reset and follows the clear sequence; stop_at >= 0 returns early
    task automatic init_seq(input int d, input int stop_at);
        logic [7:0] iv;
        iv = ival_of(d);
        rst_n[d] = 1'b1;
        for (int i = 0; i < int'(len_of(d)); i++) begin
            @(negedge clk);
            chk($sformatf("d%0d_init_w%0d", d, i),
                32'({mem_cs[d], mem_we[d], req_ready[d], init_done[d], rsp_valid[d],
                     mem_addr[d], mem_wdata[d]}),
                32'({5'b11000, 4'(i), iv}));
            if (i == stop_at) return;
        end
        @(negedge clk);
        chk($sformatf("d%0d_init_end", d),
            32'({mem_cs[d], mem_we[d], req_ready[d], init_done[d], rsp_valid[d]}),
            32'(5'b00110));
        for (int a = 0; a < 16; a++) ref_mem[d][a] = iv;
    endtask

    task automatic wait_ready(input int d, input string tag);
        for (int n = 0; n < 20 && !req_ready[d]; n++) @(negedge clk);
        chk($sformatf("d%0d_%s_rdy", d, tag), 32'(req_ready[d]), 32'd1);
    endtask

    task automatic do_write(input int d, input logic [3:0] a, input logic [7:0] data);
        int  c0;
        bit  in_rng;
        in_rng       = 32'(a) < len_of(d);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b1;
        req_addr[d]  = a;
        req_wdata[d] = data;
        wait_ready(d, "wr");
        c0 = cs_cnt[d];
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk($sformatf("d%0d_wr%0h_rdy_drop", d, a), 32'(req_ready[d]), 32'd0);
        @(negedge clk);
        chk($sformatf("d%0d_wr%0h_cs", d, a), 32'(cs_cnt[d] - c0), in_rng ? 32'd1 : 32'd0);
        chk($sformatf("d%0d_wr%0h_rdy_back", d, a), 32'(req_ready[d]), 32'd1);
        if (in_rng) ref_mem[d][a] = data;
    endtask

    task automatic do_read(input int d, input logic [3:0] a, input int hold);
        int         c0;
        int         n;
        bit         oor;
        logic [7:0] exp_data;
        oor          = 32'(a) >= len_of(d);
        exp_data     = oor ? 8'h00 : ref_mem[d][a];
        rsp_ready[d] = (hold == 0);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b0;
        req_addr[d]  = a;
        wait_ready(d, "rd");
        c0 = cs_cnt[d];
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 0;
        while (!rsp_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d_rd%0h_lat", d, a), 32'(n), oor ? 32'd0 : 32'(lat_of(d) + 1));
        chk($sformatf("d%0d_rd%0h_data", d, a),
            32'({rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]}),
            32'({1'b1, oor, exp_data, 1'b0}));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("d%0d_rd%0h_hold%0d", d, a, h),
                32'({rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]}),
                32'({1'b1, oor, exp_data, 1'b0}));
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk($sformatf("d%0d_rd%0h_done", d, a), 32'({rsp_valid[d], req_ready[d]}), 32'(2'b01));
        chk($sformatf("d%0d_rd%0h_cs", d, a), 32'(cs_cnt[d] - c0), oor ? 32'd0 : 32'd1);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_zero(d, "por");

        // Clear sequence on both controllers
        init_seq(0, -1);
        init_seq(1, -1);

        // Single write then read-back
        do_write(0, 4'h3, 8'hA5);
        do_read(0, 4'h3, 0);

        // One-hot patterns across the whole array
        for (int i = 0; i < 16; i++) do_write(0, 4'(i), 8'(8'h80 >> (i % 8)));
        for (int i = 0; i < 16; i++) do_read(0, 4'(i), 0);

        // Response back-pressure
        do_read(0, 4'h7, 5);

        // Out-of-range accesses on the 12-word controller, plus cleared-value read
        do_write(1, 4'hD, 8'h3C);
        do_read(1, 4'hD, 0);
        do_read(1, 4'h2, 1);
        do_write(1, 4'hB, 8'hC3);
        do_read(1, 4'hB, 0);

        // Randomized traffic on both controllers
        repeat (160) begin
            int         d;
            logic [3:0] a;
            logic [7:0] wd;
            d  = int'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(d, a, wd);
            else                           do_read(d, a, int'($urandom_range(0, 3)));
        end

        // Reset mid-clear, then mid-response
        reset_pulse(0);
        init_seq(0, 7);
        reset_pulse(0);
        init_seq(0, -1);
        do_write(0, 4'h9, 8'h66);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 4'h9;
        wait_ready(0, "rsp_rst");
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int n = 0; n < 20 && !rsp_valid[0]; n++) @(negedge clk);
        chk("d0_rsp_before_rst", 32'({rsp_valid[0], rsp_rdata[0]}), 32'({1'b1, 8'h66}));
        reset_pulse(0);
        init_seq(0, -1);
        do_read(0, 4'h9, 0);
        do_read(0, 4'h0, 2);

        for (int d = 0; d < NDUT; d++)
            chk($sformatf("d%0d_bus_protocol", d), 32'(viol[d]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Initiator-side controller for the single-port synchronous SRAM block. It drives the SRAM's CS/WE/addr/data_in pins and reads its data_out. It accepts word read/write requests from the CPU datapath over a valid/ready handshake and returns read data over a valid/ready response channel. After reset it clears the whole array to INIT_VAL before accepting any request.

Parameters:
ADDR, 4, address width in bits; matches the SRAM ADDR parameter.
WIDTH, 8, data word width; matches the SRAM WIDTH parameter.
LENGTH, 16, number of implemented words (LENGTH ≤ 2^ADDR).
RD_LAT, 1, cycles from the read-issue edge until mem_rdata is valid (range 1..4).
INIT_EN, 1, 1 = run the clear sequence after reset; 0 = go straight to IDLE.
INIT_VAL, 0, word written to every location during the clear sequence.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR  word address.
req_wdata  in  WIDTH  write data.
rsp_valid  out  1  read response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  WIDTH  read data.
rsp_err  out  1  request address was ≥ LENGTH.
init_done  out  1  clear sequence finished; stays high until the next reset.
mem_cs  out  1  SRAM chip select (CS).
mem_we  out  1  SRAM write enable (WE); 1 = write, 0 = read.
mem_addr  out  ADDR  SRAM address.
mem_wdata  out  WIDTH  SRAM data_in.
mem_rdata  in  WIDTH  SRAM data_out.

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- While rst_n = 0, every output is 0: req_ready, rsp_valid, rsp_rdata, rsp_err, init_done, mem_cs, mem_we, mem_addr, mem_wdata.
- All mem_* outputs and all response outputs are registered.
- States:
  - INIT: entered on reset release if INIT_EN = 1, otherwise go to IDLE.
  - INIT operation: a counter runs 0..LENGTH-1, one write per cycle (mem_cs=1, mem_we=1, mem_addr=count, mem_wdata=INIT_VAL). After the last write, mem_cs=0, init_done=1 and the state moves to IDLE.
  - IDLE: req_ready=1 only when init_done=1 and no response is pending. A transfer happens on a clk edge with req_valid && req_ready; req_ready drops to 0 on the next cycle.
  - WR: one cycle with mem_cs=1, mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata (all captured at accept). Then back to IDLE. Write throughput is 1 request per 2 cycles; no write response is generated.
  - RD: one cycle with mem_cs=1, mem_we=0, mem_addr=req_addr.
  - WAIT: mem_cs=0. Count RD_LAT cycles from the RD edge, then capture mem_rdata into rsp_rdata.
  - RSP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready, then return to IDLE.
  - Read latency with RD_LAT=1 and rsp_ready=1: the request is accepted at edge N, and rsp_valid is high in the cycle after edge N+2.
- Out-of-range address (req_addr ≥ LENGTH):
  - Write: no mem_cs pulse; the request is silently dropped.
  - Read: no mem_cs pulse; go directly to RSP with rsp_rdata=0 and rsp_err=1.
- mem_cs is never asserted outside the INIT, WR and RD states. mem_we=0 whenever mem_cs=0.
- No request is accepted while rsp_valid=1, so responses stay in request order.
- Reset mid-operation: all outputs clear asynchronously. Any pending request and response are lost. A partial write cycle may corrupt only that single word. The clear sequence restarts from address 0.
- Widths: the INIT counter is ADDR+1 bits, so LENGTH = 2^ADDR terminates. The WAIT counter is 3 bits.

Decomposition:
- Shared package sram_ctrl_pkg holds the state encoding localparams (S_INIT, S_IDLE, S_WR, S_RD, S_WAIT, S_RSP) and the WE polarity constants MEM_WE_WRITE=1 and MEM_WE_READ=0.
- The SRAM block itself also uses the WE polarity constants.
- No sub-module: a single FSM plus two counters, about 200 lines.

Test Plan:
1. Reset release, INIT_EN=1, LENGTH=16 → 16 consecutive mem_cs/mem_we pulses at addresses 0..15 with data 8'h00. init_done rises on the next edge. req_ready=0 throughout the sequence.
2. Write addr 4'h3 = 8'hA5, then read addr 4'h3 (rsp_ready=1) → rsp_valid is high 3 cycles after the read accept, with rsp_rdata=8'hA5 and rsp_err=0.
3. Write 8'h80>>i to addresses 0..15, then read them back, matching the original bench's one-hot bit patterns → every word matches. With LENGTH=16 and ADDR=4 there is no aliasing.
4. Read addr 4'h7 with rsp_ready held at 0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready → handshake completes and req_ready=1 on the next cycle.
5. With LENGTH=12: write addr 4'hD, then read addr 4'hD → no mem_cs pulse for either request. The read returns rsp_rdata=0 and rsp_err=1.
6. Assert rst_n=0 mid-INIT (at count 7) and mid-RSP → all outputs are 0 immediately. After release, the clear sequence restarts at address 0 and no stale rsp_valid appears.
